gray_updown_counter: RTL

Parametrised modulo-N up/down counter with registered binary and Gray-coded outputs, synchronous load, count enable and a registered wrap pulse. It is the general-width successor to the team's fixed 3-bit, modulo-5 load/direction counter. It sits in sequencing and timebase logic wherever a bounded position counter with a direction mode is needed. The Gray output is suitable for crossing to other logic when `MODULUS` is a power of two.

---
 rtl/gray_updown_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - modulo-N up/down counter with registered binary, Gray and wrap outputs
module gray_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             direction,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             up
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_value_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_count <= '0;
      r_gray  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_gray  <= w_count_next ^ (w_count_next >> 1);
      r_wrap  <= w_wrap_next;
    end
  end

  // Widened compare so a MODULUS of 2^WIDTH never saturates a legal value
  assign w_value_sat = ({1'b0, value} < MOD_EXT) ? value : MAX_VAL;

  always_comb begin
    w_state_next = direction ? S_UP : S_DOWN;
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (r_state != S_INIT && r_state != S_UP && r_state != S_DOWN) begin
      w_state_next = S_INIT;
      w_count_next = '0;
    end else if (load) begin
      w_count_next = w_value_sat;
    end else begin
      case (r_state)
        S_INIT: w_count_next = '0;
        S_UP: begin
          if (en) begin
            if (r_count == MAX_VAL) begin
              w_count_next = '0;
              w_wrap_next  = 1'b1;
            end else begin
              w_count_next = r_count + 1'b1;
            end
          end
        end
        S_DOWN: begin
          if (en) begin
            if (r_count == '0) begin
              w_count_next = MAX_VAL;
              w_wrap_next  = 1'b1;
            end else begin
              w_count_next = r_count - 1'b1;
            end
          end
        end
        default: w_count_next = '0;
      endcase
    end
  end

  assign count = r_count;
  assign gray  = r_gray;
  assign wrap  = r_wrap;
  assign up    = (r_state == S_UP);

endmodule
